// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment digit counter.
//   SEG_W / DIGIT_W : segment bus and digit widths
//   SEG_0..SEG_F    : active-high segment patterns, bit0=a .. bit6=g
//   seg7_decode()   : hex digit -> active-high segment pattern
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1110001;

  function automatic logic [SEG_W-1:0] seg7_decode(input logic [DIGIT_W-1:0] d);
    logic [SEG_W-1:0] p;
    p = SEG_0;
    case (d)
      4'h0: p = SEG_0;
      4'h1: p = SEG_1;
      4'h2: p = SEG_2;
      4'h3: p = SEG_3;
      4'h4: p = SEG_4;
      4'h5: p = SEG_5;
      4'h6: p = SEG_6;
      4'h7: p = SEG_7;
      4'h8: p = SEG_8;
      4'h9: p = SEG_9;
      4'hA: p = SEG_A;
      4'hB: p = SEG_B;
      4'hC: p = SEG_C;
      4'hD: p = SEG_D;
      4'hE: p = SEG_E;
      4'hF: p = SEG_F;
      default: p = SEG_0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronises the slow asynchronous tick into clk_in and emits a one-cycle
// event per rising edge.
//   clk_in   : system clock
//   rst      : synchronous active-high reset
//   tick_in  : asynchronous tick square wave
//   tick_evt : one-cycle pulse per detected tick_in rising edge
module tick_sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_in,
  output logic tick_evt
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       r_armed;
  logic [1:0] r_arm_cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_armed   <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_s1 <= tick_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // Arming lags reset release by three edges so a tick_in already high
      // at release clears the edge detector before events are accepted.
      if (!r_armed) begin
        if (r_arm_cnt == 2'd2) r_armed   <= 1'b1;
        else                   r_arm_cnt <= r_arm_cnt + 2'd1;
      end
    end
  end

  assign tick_evt = r_s2 & ~r_s3 & r_armed;

endmodule

// File: rtl/digit_counter_7seg.sv
// Single-digit up/down modulo counter with 7-segment decode.
//   clk_in   : system clock
//   rst      : synchronous active-high reset
//   tick_in  : asynchronous tick; each rising edge is one count event
//   en       : count enable (events dropped while low)
//   up_dn    : 1 = count up, 0 = count down
//   load     : synchronous load strobe, overrides a coincident event
//   load_val : value to load (clamped to MODULUS-1)
//   digit    : current count
//   seg      : segment drive, seg[0]=a .. seg[6]=g, polarity per COMMON_ANODE
//   carry    : one-cycle pulse on wrap in either direction
module digit_counter_7seg
  import seg7_pkg::*;
#(
  parameter int unsigned MODULUS      = 10,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(MODULUS - 1);
  localparam logic [SEG_W-1:0]   SEG_RST   = COMMON_ANODE ? ~SEG_0 : SEG_0;

  logic               w_evt;
  logic [DIGIT_W-1:0] w_next;
  logic               w_carry;
  logic [SEG_W-1:0]   w_seg_hi;
  logic [SEG_W-1:0]   w_seg;

  tick_sync_edge u_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .tick_evt (w_evt)
  );

  always_comb begin
    w_next  = digit;
    w_carry = 1'b0;
    if (load) begin
      w_next = (32'(load_val) >= MODULUS) ? MAX_DIGIT : load_val;
    end else if (w_evt && en) begin
      if (up_dn) begin
        if (digit == MAX_DIGIT) begin
          w_next  = '0;
          w_carry = 1'b1;
        end else begin
          w_next = digit + DIGIT_W'(1);
        end
      end else begin
        if (digit == '0) begin
          w_next  = MAX_DIGIT;
          w_carry = 1'b1;
        end else begin
          w_next = digit - DIGIT_W'(1);
        end
      end
    end
  end

  // Decode the next value so seg is registered on the same edge as digit.
  always_comb begin
    w_seg_hi = seg7_decode(w_next);
    w_seg    = COMMON_ANODE ? ~w_seg_hi : w_seg_hi;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      digit <= '0;
      seg   <= SEG_RST;
      carry <= 1'b0;
    end else begin
      digit <= w_next;
      seg   <= w_seg;
      carry <= w_carry;
    end
  end

endmodule

// File: tb/tb_digit_counter_7seg.sv
module tb_digit_counter_7seg;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       en = 1'b1;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] digit10, digit16;
  logic [6:0] seg10, seg16;
  logic       carry10, carry16;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Bench-side model state
  logic [3:0] m10 = 4'd0;
  logic [3:0] m16 = 4'd0;

  typedef struct {
    logic [3:0] d10;
    logic [6:0] s10;
    logic       c10;
    logic [3:0] d16;
    logic [6:0] s16;
    logic       c16;
  } exp_t;

  exp_t sb[$];

  always #10 clk_in = ~clk_in;

  digit_counter_7seg #(.MODULUS(10), .COMMON_ANODE(1'b1)) dut10 (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .digit(digit10), .seg(seg10), .carry(carry10)
  );

  digit_counter_7seg #(.MODULUS(16), .COMMON_ANODE(1'b0)) dut16 (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .digit(digit16), .seg(seg16), .carry(carry16)
  );

  function automatic logic [6:0] m_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // {carry, next digit}
  function automatic logic [4:0] m_next(input logic [3:0] d, input int unsigned mod,
                                        input logic up);
    if (up) return (32'(d) == mod - 1) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    else    return (d == 4'd0) ? {1'b1, 4'(mod - 1)} : {1'b0, d - 4'd1};
  endfunction

  // One tick_in pulse; the expected outputs are queued when the pulse is
  // driven and popped when the outputs should have updated (third edge).
  task automatic tick();
    exp_t       e;
    logic [4:0] r10, r16;
    logic [3:0] old10, old16;
    old10 = m10;
    old16 = m16;
    r10 = m_next(m10, 10, up_dn);
    r16 = m_next(m16, 16, up_dn);
    if (!en) begin
      r10 = {1'b0, m10};
      r16 = {1'b0, m16};
    end
    e.d10 = r10[3:0]; e.s10 = ~m_seg(r10[3:0]); e.c10 = r10[4];
    e.d16 = r16[3:0]; e.s16 =  m_seg(r16[3:0]); e.c16 = r16[4];
    @(negedge clk_in);
    tick_in = 1'b1;
    sb.push_back(e);
    m10 = r10[3:0];
    m16 = r16[3:0];
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    n_vec++;
    if (digit10 !== old10 || digit16 !== old16) begin
      n_err++;
      $display("FAIL tick_latency: digit10=%h digit16=%h expected %h %h", digit10, digit16, old10, old16);
    end
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (digit10 !== e.d10 || seg10 !== e.s10 || carry10 !== e.c10) begin
      n_err++;
      $display("FAIL tick_dut10: digit=%h seg=%b carry=%b expected %h %b %b",
               digit10, seg10, carry10, e.d10, e.s10, e.c10);
    end
    n_vec++;
    if (digit16 !== e.d16 || seg16 !== e.s16 || carry16 !== e.c16) begin
      n_err++;
      $display("FAIL tick_dut16: digit=%h seg=%b carry=%b expected %h %b %b",
               digit16, seg16, carry16, e.d16, e.s16, e.c16);
    end
    @(posedge clk_in);
    #1;
    n_vec++;
    if (carry10 !== 1'b0 || carry16 !== 1'b0 || digit10 !== e.d10 || digit16 !== e.d16) begin
      n_err++;
      $display("FAIL tick_after: carry10=%b carry16=%b digit10=%h digit16=%h expected 0 0 %h %h",
               carry10, carry16, digit10, digit16, e.d10, e.d16);
    end
    @(negedge clk_in);
    tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst = 1'b1;
    m10 = 4'd0;
    m16 = 4'd0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (digit10 !== 4'd0 || seg10 !== 7'b1000000 || carry10 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dut10: digit=%h seg=%b carry=%b expected 0 1000000 0", digit10, seg10, carry10);
    end
    n_vec++;
    if (digit16 !== 4'd0 || seg16 !== 7'b0111111 || carry16 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dut16: digit=%h seg=%b carry=%b expected 0 0111111 0", digit16, seg16, carry16);
    end
    release_reset();
  endtask

  task automatic test_up_count();
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (digit10 !== 4'd0 || seg10 !== 7'b1000000) begin
      n_err++;
      $display("FAIL up_wrap_seg: digit=%h seg=%b expected 0 1000000", digit10, seg10);
    end
  endtask

  task automatic test_down();
    up_dn = 1'b0;
    tick();
    n_vec++;
    if (digit10 !== 4'd9 || seg10 !== 7'b0010000) begin
      n_err++;
      $display("FAIL down_wrap_seg: digit=%h seg=%b expected 9 0010000", digit10, seg10);
    end
    up_dn = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk_in);
    load = 1'b1;
    load_val = 4'd12;
    @(posedge clk_in);
    #1;
    n_vec++;
    if (digit10 !== 4'd9 || seg10 !== ~m_seg(4'd9) || digit16 !== 4'd12 || seg16 !== m_seg(4'd12)) begin
      n_err++;
      $display("FAIL load_clamp: digit10=%h seg10=%b digit16=%h seg16=%b expected 9 %b c %b",
               digit10, seg10, digit16, seg16, ~m_seg(4'd9), m_seg(4'd12));
    end
    @(negedge clk_in);
    load = 1'b0;
    m10 = 4'd9;
    m16 = 4'd12;
    repeat (2) @(negedge clk_in);
    // Event would wrap dut10 (9->0, carry); load lands on the detection edge.
    tick_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    load = 1'b1;
    load_val = 4'd3;
    @(posedge clk_in);
    #1;
    n_vec++;
    if (digit10 !== 4'd3 || carry10 !== 1'b0 || digit16 !== 4'd3 || carry16 !== 1'b0) begin
      n_err++;
      $display("FAIL load_vs_event: digit10=%h carry10=%b digit16=%h carry16=%b expected 3 0 3 0",
               digit10, carry10, digit16, carry16);
    end
    @(negedge clk_in);
    load = 1'b0;
    m10 = 4'd3;
    m16 = 4'd3;
    repeat (3) @(posedge clk_in);
    #1;
    n_vec++;
    if (digit10 !== 4'd3 || digit16 !== 4'd3 || carry10 !== 1'b0 || carry16 !== 1'b0) begin
      n_err++;
      $display("FAIL load_event_lost: digit10=%h digit16=%h expected 3 3", digit10, digit16);
    end
    @(negedge clk_in);
    tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_enable();
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b1;
    tick();
  endtask

  task automatic test_hold();
    int unsigned carries;
    carries = 0;
    @(negedge clk_in);
    tick_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_in);
      #1;
      if (carry10 === 1'b1 || carry16 === 1'b1) carries++;
    end
    m10 = m_next(m10, 10, up_dn) >> 0;
    m16 = m_next(m16, 16, up_dn) >> 0;
    n_vec++;
    if (digit10 !== m10 || digit16 !== m16 || carries != 0) begin
      n_err++;
      $display("FAIL hold_high: digit10=%h digit16=%h carries=%0d expected %h %h 0",
               digit10, digit16, carries, m10, m16);
    end
    @(negedge clk_in);
    tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_reset_tick_high();
    apply_reset();
    tick_in = 1'b1;
    release_reset();
    repeat (10) @(negedge clk_in);
    n_vec++;
    if (digit10 !== 4'd0 || digit16 !== 4'd0 || carry10 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tick_high: digit10=%h digit16=%h expected 0 0", digit10, digit16);
    end
    tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_reset_inflight();
    tick_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    m10 = 4'd0;
    m16 = 4'd0;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (8) @(negedge clk_in);
    n_vec++;
    if (digit10 !== 4'd0 || digit16 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_inflight: digit10=%h digit16=%h expected 0 0", digit10, digit16);
    end
    tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
    up_dn = 1'b1;
    tick();
  endtask

  task automatic test_mod16();
    apply_reset();
    release_reset();
    up_dn = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    n_vec++;
    if (digit16 !== 4'hF || seg16 !== 7'b1110001) begin
      n_err++;
      $display("FAIL mod16_f: digit=%h seg=%b expected f 1110001", digit16, seg16);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_count();
    test_down();
    test_load();
    test_enable();
    test_hold();
    test_reset_tick_high();
    test_reset_inflight();
    test_mod16();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
